anim_sequencer: RTL and testbench
=================================

// Module: anim_sequencer
// PURPOSE
//  Parametrised sprite-animation sequencer. Steps through a table of up to
//  MAX_FRAMES sprite-sheet frames on anim_tick, holding each for its own tick
//  count, and drives anim_row/anim_col to the character sprite renderer.
//  Run-time modes: one-shot (hold last frame), loop, ping-pong; restartable.
//  One instance per character action replaces per-move fixed frame FSMs.
// PARAMETERS
//  MAX_FRAMES  8   table depth (>=2); frame index width IDX_W = $clog2(MAX_FRAMES)
//  COORD_W     11  width of sprite-sheet row/col coordinates
//  HOLD_W      5   width of per-frame hold count (ticks)
// PORTS
//  clk        in   1                  system clock
//  reset_n    in   1                  async active-low reset
//  anim_tick  in   1                  1-cycle animation-rate strobe
//  start      in   1                  1-cycle pulse: (re)start sequence at frame 0
//  pause      in   1                  level: freeze hold counter/frame while high
//  mode       in   2                  0 one-shot, 1 loop, 2 ping-pong, 3 = one-shot
//  num_frames in   IDX_W+1            active frame count, sampled on start
//  row_tbl    in   MAX_FRAMES*COORD_W frame i row at [i*COORD_W +: COORD_W]
//  col_tbl    in   MAX_FRAMES*COORD_W frame i col, same packing
//  hold_tbl   in   MAX_FRAMES*HOLD_W  frame i hold ticks, same packing
//  anim_row   out  COORD_W            row of current frame
//  anim_col   out  COORD_W            col of current frame
//  frame_idx  out  IDX_W              current frame index
//  busy       out  1                  high in PLAY
//  frame_adv  out  1                  1-cycle pulse on every frame change
//  done       out  1                  1-cycle pulse when one-shot completes
// BEHAVIOUR
//  - Reset (async assert, sync-release use): state IDLE, frame_idx 0, hold_cnt 0,
//    dir up, busy/frame_adv/done 0; anim_row/col = table entry 0.
//  - anim_row/col = table[frame_idx], combinational from registered frame_idx;
//    tables are quasi-static, changes while busy take effect immediately.
//  - States: IDLE -> PLAY on start; PLAY -> FINISH on one-shot end;
//    FINISH -> PLAY on start. FINISH holds the last frame indefinitely.
//  - start (any state, any cycle): frame_idx<=0, hold_cnt<=0, dir<=up, latch
//    mode and len; enter PLAY next cycle. start beats anim_tick and pause in the
//    same cycle; frame_adv is not pulsed on restart.
//  - len = num_frames clamped to [1, MAX_FRAMES] (0 -> 1, >MAX -> MAX).
//  - hold h = hold_tbl[frame_idx]; h==0 treated as 1.
//  - In PLAY, on anim_tick with pause low: if hold_cnt==h-1 then hold_cnt<=0 and
//    advance; else hold_cnt++. pause high or tick low: no change.
//  - Advance: one-shot: idx<len-1 -> idx+1, frame_adv=1; idx==len-1 -> FINISH,
//    done=1, idx unchanged, no frame_adv. loop: idx==len-1 -> 0, else +1;
//    frame_adv=1. ping-pong: dir flips at idx==len-1 (up) and idx==0 (down),
//    endpoints shown once per bounce (0,1,2,1,0,1..); frame_adv=1.
//  - len==1: loop/ping-pong stay on frame 0, frame_adv still pulses per period;
//    one-shot finishes after h ticks.
//  - frame_adv/done are registered: high the cycle after the advancing tick.
//  - Latency: first frame-0 period = exactly h ticks after the start cycle.
//  - IDLE/FINISH ignore anim_tick and pause. busy = (state==PLAY).
//  - Reset mid-sequence: immediate return to reset values, no done pulse.
// TESTING
//  1 reset; len=3 hold={5,5,6} one-shot, start -> idx 0,1,2 after 5,10 ticks;
//    done at tick 16, then idx stays 2, busy 0, further ticks no change.
//  2 loop len=3 hold={2,2,2} -> idx seq 0,0,1,1,2,2,0; frame_adv every 2 ticks.
//  3 ping-pong len=4 hold=1 -> idx 0,1,2,3,2,1,0,1; num_frames=0 start -> len 1.
//  4 pause high for 10 ticks mid-frame -> hold_cnt/idx frozen; resumes exact count.
//  5 start coincident with advancing tick at idx 2 -> idx 0, no frame_adv/done.
//  6 reset_n low mid-PLAY (idx 2) -> async idx 0, busy 0, row/col = entry 0.

Source files
------------

// File: rtl/anim_sequencer.sv
// anim_sequencer: steps through a sprite-sheet frame table on anim_tick with
// per-frame hold counts; one-shot, loop and ping-pong playback.
module anim_sequencer #(
    parameter int MAX_FRAMES = 8,
    parameter int COORD_W    = 11,
    parameter int HOLD_W     = 5,
    localparam int IDX_W     = $clog2(MAX_FRAMES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          anim_tick,
    input  logic                          start,
    input  logic                          pause,
    input  logic [1:0]                    mode,
    input  logic [IDX_W:0]                num_frames,
    input  logic [MAX_FRAMES*COORD_W-1:0] row_tbl,
    input  logic [MAX_FRAMES*COORD_W-1:0] col_tbl,
    input  logic [MAX_FRAMES*HOLD_W-1:0]  hold_tbl,
    output logic [COORD_W-1:0]            anim_row,
    output logic [COORD_W-1:0]            anim_col,
    output logic [IDX_W-1:0]              frame_idx,
    output logic                          busy,
    output logic                          frame_adv,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_FRAMES);
    localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W:0]      len_q, len_d;
    logic                frame_adv_q, frame_adv_d;
    logic                done_q, done_d;
    logic [HOLD_W-1:0]   h, h_m1;
    logic [IDX_W:0]      len_in;
    logic                last;
    assign h         = hold_tbl[idx_q*HOLD_W +: HOLD_W];
    assign h_m1      = (h == '0) ? '0 : h - 1'b1;
    assign len_in    = (num_frames == '0) ? LEN_ONE : (num_frames > LEN_MAX) ? LEN_MAX : num_frames;
    assign last      = ({1'b0, idx_q} == len_q - 1'b1);
    assign anim_row  = row_tbl[idx_q*COORD_W +: COORD_W];
    assign anim_col  = col_tbl[idx_q*COORD_W +: COORD_W];
    assign frame_idx = idx_q;
    assign busy      = (state_q == PLAY);
    assign frame_adv = frame_adv_q;
    assign done      = done_q;
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        len_d       = len_q;
        frame_adv_d = 1'b0;
        done_d      = 1'b0;
        if (start) begin
            state_d    = PLAY;
            idx_d      = '0;
            hold_cnt_d = '0;
            dir_d      = 1'b0;
            mode_d     = mode;
            len_d      = len_in;
        end else if (state_q == PLAY && anim_tick && !pause) begin
            if (hold_cnt_q != h_m1) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = '0;
                if (mode_q == 2'd1) begin
                    idx_d       = last ? '0 : idx_q + 1'b1;
                    frame_adv_d = 1'b1;
                end else if (mode_q == 2'd2) begin
                    // dir_q: 0 counting up, 1 counting down; endpoints shown once per bounce
                    frame_adv_d = 1'b1;
                    if (len_q == LEN_ONE) begin
                        idx_d = '0;
                    end else if (!dir_q) begin
                        dir_d = last;
                        idx_d = last ? idx_q - 1'b1 : idx_q + 1'b1;
                    end else begin
                        dir_d = (idx_q != '0);
                        idx_d = (idx_q == '0) ? idx_q + 1'b1 : idx_q - 1'b1;
                    end
                end else if (last) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    frame_adv_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            dir_q       <= 1'b0;
            mode_q      <= 2'd0;
            len_q       <= LEN_ONE;
            frame_adv_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            frame_adv_q <= frame_adv_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: directed checks of playback modes, pause, restart and reset.
module tb_anim_sequencer;
    localparam int MF = 8, CW = 11, HW = 5, IW = 3;
    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           anim_tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [IW:0]    num_frames = '0;
    logic [MF*CW-1:0] row_tbl, col_tbl;
    logic [MF*HW-1:0] hold_tbl;
    logic [CW-1:0]  anim_row, anim_col;
    logic [IW-1:0]  frame_idx;
    logic           busy, frame_adv, done;
    int vectors = 0, errors = 0;

    anim_sequencer #(.MAX_FRAMES(MF), .COORD_W(CW), .HOLD_W(HW)) dut (
        .clk(clk), .reset_n(reset_n), .anim_tick(anim_tick), .start(start),
        .pause(pause), .mode(mode), .num_frames(num_frames), .row_tbl(row_tbl),
        .col_tbl(col_tbl), .hold_tbl(hold_tbl), .anim_row(anim_row),
        .anim_col(anim_col), .frame_idx(frame_idx), .busy(busy),
        .frame_adv(frame_adv), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic tk, input logic pa);
        start = st;
        anim_tick = tk;
        pause = pa;
        @(posedge clk);
        #1;
        start = 1'b0;
        anim_tick = 1'b0;
    endtask

    task automatic set_holds(input int h0, input int h1, input int h2, input int h3, input int rest);
        for (int i = 0; i < MF; i++)
            hold_tbl[i*HW +: HW] = HW'((i == 0) ? h0 : (i == 1) ? h1 : (i == 2) ? h2 : (i == 3) ? h3 : rest);
    endtask

    task automatic go(input logic [1:0] m, input logic [IW:0] n);
        mode = m;
        num_frames = n;
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_idx[7];
        int exp_adv[7];
        for (int i = 0; i < MF; i++) begin
            row_tbl[i*CW +: CW] = CW'(100 + i);
            col_tbl[i*CW +: CW] = CW'(200 + i);
        end
        set_holds(5, 5, 6, 1, 1);
        #12;
        chk("rst_idx", frame_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_row", anim_row, 100);
        chk("rst_col", anim_col, 200);
        chk("rst_adv", frame_adv, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // one-shot, len 3, hold {5,5,6}
        go(2'd0, 4'd3);
        chk("os_busy", busy, 1);
        chk("os_idx0", frame_idx, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        chk("os_idx_t4", frame_idx, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("os_idx_t5", frame_idx, 1);
        chk("os_adv_t5", frame_adv, 1);
        chk("os_row_t5", anim_row, 101);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        chk("os_idx_t10", frame_idx, 2);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        chk("os_done_t15", done, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("os_done_t16", done, 1);
        chk("os_adv_t16", frame_adv, 0);
        chk("os_idx_t16", frame_idx, 2);
        chk("os_busy_t16", busy, 0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("fin_idx", frame_idx, 2);
        chk("fin_done", done, 0);
        chk("fin_col", anim_col, 202);

        // loop, len 3, hold 2
        set_holds(2, 2, 2, 2, 2);
        go(2'd1, 4'd3);
        exp_idx = '{0, 1, 1, 2, 2, 0, 0};
        exp_adv = '{0, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("loop_idx_t%0d", i + 1), frame_idx, exp_idx[i]);
            chk($sformatf("loop_adv_t%0d", i + 1), frame_adv, exp_adv[i]);
        end

        // ping-pong, len 4, hold 1 (entry 3 hold 0 treated as 1)
        set_holds(1, 1, 1, 0, 1);
        go(2'd2, 4'd4);
        exp_idx = '{1, 2, 3, 2, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("pp_idx_t%0d", i + 1), frame_idx, exp_idx[i]);
            chk($sformatf("pp_adv_t%0d", i + 1), frame_adv, 1);
        end
        go(2'd2, 4'd0);
        repeat (2) begin
            step(1'b0, 1'b1, 1'b0);
            chk("pp1_idx", frame_idx, 0);
            chk("pp1_adv", frame_adv, 1);
        end

        // num_frames above MAX clamps to 8
        go(2'd1, 4'd15);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        chk("clamp_idx7", frame_idx, 7);
        step(1'b0, 1'b1, 1'b0);
        chk("clamp_wrap", frame_idx, 0);

        // pause freezes hold count mid-frame
        set_holds(5, 5, 5, 5, 5);
        go(2'd1, 4'd3);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1);
        chk("pause_idx", frame_idx, 0);
        chk("pause_adv", frame_adv, 0);
        chk("pause_busy", busy, 1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        chk("resume_idx_t4", frame_idx, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("resume_idx_t5", frame_idx, 1);

        // start beats an advancing tick at idx 2
        set_holds(1, 1, 1, 1, 1);
        go(2'd0, 4'd3);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        chk("rs_pre_idx", frame_idx, 2);
        step(1'b1, 1'b1, 1'b0);
        chk("rs_idx", frame_idx, 0);
        chk("rs_adv", frame_adv, 0);
        chk("rs_done", done, 0);
        chk("rs_busy", busy, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("rs_next_idx", frame_idx, 1);

        // asynchronous reset mid-PLAY
        step(1'b0, 1'b1, 1'b0);
        chk("ar_pre_idx", frame_idx, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_idx", frame_idx, 0);
        chk("ar_busy", busy, 0);
        chk("ar_row", anim_row, 100);
        chk("ar_col", anim_col, 200);
        chk("ar_done", done, 0);
        #3 reset_n = 1'b1;
        repeat (2) step(1'b0, 1'b1, 1'b0);
        chk("ar_idle_idx", frame_idx, 0);
        chk("ar_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
